// File: rtl/combo_lock_pkg.sv
`timescale 1ns/1ps
// combo_lock_pkg: shared types, press codes, display-select codes and
// digit helpers for the combination-lock controller.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        FAIL    = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4,
        PROG    = 3'd5
    } state_t;

    localparam int unsigned CODE_W  = 16;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [2:0] PB_SHORT = 3'b001;
    localparam logic [2:0] PB_LONG  = 3'b010;

    localparam logic [2:0] SEL_OPEN = 3'd4;
    localparam logic [2:0] SEL_FAIL = 3'd5;
    localparam logic [2:0] SEL_LOCK = 3'd6;
    localparam logic [2:0] SEL_PROG = 3'd7;

    // Mask selecting the first len digits of an MSB-first packed code.
    function automatic logic [CODE_W-1:0] digit_mask(input int unsigned len);
        return 16'hFFFF << (16 - 4 * len);
    endfunction

    // Write digit d into slot idx (slot 0 lives in [15:12]).
    function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] code,
                                                    input logic [1:0]        idx,
                                                    input logic [DIGIT_W-1:0] d);
        logic [CODE_W-1:0] r;
        r = code;
        case (idx)
            2'd0: r[15:12] = d;
            2'd1: r[11:8]  = d;
            2'd2: r[7:4]   = d;
            2'd3: r[3:0]   = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/combo_lock_timer.sv
`timescale 1ns/1ps
// combo_lock_timer: saturating up-counter cleared on request, with a
// combinational terminal-count flag when the count equals limit.
// Ports: clk, rstn (async active-low), clr (restart from 0),
//        limit (terminal value), tc_c (count == limit).
module combo_lock_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc_c
);

    logic [W-1:0] cnt;

    // Counts up from 0 after each clear and holds at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {W{1'b1}}) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc_c = (cnt == limit);

endmodule

// File: rtl/combo_lock_ctrl.sv
`timescale 1ns/1ps
// combo_lock_ctrl: collects a code from encoder digits and button presses,
// compares it with the stored code, and sequences OPEN / FAIL / LOCKOUT.
// Optional macro COMBO_LOCK_PROGRAM_EN adds PROG mode (reprogram code).
// Ports: clk, rstn (async active-low), enc[3:0] live digit,
//        pb_press_type[2:0] press pulse, display_value[3:0],
//        display_select[2:0], unlocked, lockout, fail_cnt[1:0].
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int unsigned  CODE_LEN       = 4,
    parameter logic [15:0]  DEFAULT_CODE   = 16'h1234,
    parameter int unsigned  MAX_FAILS      = 3,
    parameter int unsigned  HOLD_CYCLES    = 5000,
    parameter int unsigned  UNLOCK_CYCLES  = 50000,
    parameter int unsigned  LOCKOUT_CYCLES = 30000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] enc,
    input  logic [2:0] pb_press_type,
    output logic [3:0] display_value,
    output logic [2:0] display_select,
    output logic       unlocked,
    output logic       lockout,
    output logic [1:0] fail_cnt
);

    localparam int unsigned MAX_HU  = (HOLD_CYCLES > UNLOCK_CYCLES) ? HOLD_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HU > LOCKOUT_CYCLES) ? MAX_HU : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CODE_W-1:0] CODE_MASK = digit_mask(CODE_LEN);
    localparam logic [1:0]        LAST_IDX  = 2'(CODE_LEN - 1);
    localparam logic [1:0]        FAIL_MAX  = 2'(MAX_FAILS);

    state_t              st, st_nxt;
    logic [1:0]          idx, idx_nxt;
    logic [CODE_W-1:0]   entry_buf, buf_nxt;
    logic [CODE_W-1:0]   code;
    logic [1:0]          fails_nxt;
    logic [3:0]          dv_nxt;
    logic [2:0]          ds_nxt;
    logic [TIMER_W-1:0]  limit;
    logic                tc_c;
    logic                short_c, long_c;

    assign short_c = (pb_press_type == PB_SHORT);
    assign long_c  = (pb_press_type == PB_LONG);

`ifdef COMBO_LOCK_PROGRAM_EN
    logic [CODE_W-1:0] code_nxt;

    // Programmable stored code; reverts to the default on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) code <= DEFAULT_CODE;
        else       code <= code_nxt;
    end
`else
    assign code = DEFAULT_CODE;
`endif

    // Dwell limit for the state currently being timed.
    always_comb begin
        limit = '1;
        case (st)
            FAIL:    limit = TIMER_W'(HOLD_CYCLES - 1);
            OPEN:    limit = TIMER_W'(UNLOCK_CYCLES - 1);
            LOCKOUT: limit = TIMER_W'(LOCKOUT_CYCLES - 1);
            default: limit = '1;
        endcase
    end

    combo_lock_timer #(.W(TIMER_W)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (st_nxt != st),
        .limit (limit),
        .tc_c  (tc_c)
    );

    // Next state, digit buffer, failure count and next output values.
    always_comb begin
        st_nxt    = st;
        idx_nxt   = idx;
        buf_nxt   = entry_buf;
        fails_nxt = fail_cnt;
`ifdef COMBO_LOCK_PROGRAM_EN
        code_nxt  = code;
`endif
        case (st)
            ENTRY: begin
                if (short_c) begin
                    buf_nxt = put_digit(entry_buf, idx, enc);
                    if (idx == LAST_IDX) begin
                        st_nxt  = CHECK;
                        idx_nxt = 2'd0;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else if (long_c) begin
                    buf_nxt = '0;
                    idx_nxt = 2'd0;
                end
            end
            CHECK: begin
                if (((entry_buf ^ code) & CODE_MASK) == '0) begin
                    st_nxt    = OPEN;
                    fails_nxt = 2'd0;
                end else begin
                    fails_nxt = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;
                    st_nxt    = (fails_nxt == FAIL_MAX) ? LOCKOUT : FAIL;
                end
            end
            FAIL: begin
                if (tc_c) st_nxt = ENTRY;
            end
            OPEN: begin
                // A press coinciding with the timeout is still one relock.
                if (short_c || tc_c) st_nxt = ENTRY;
`ifdef COMBO_LOCK_PROGRAM_EN
                else if (long_c) st_nxt = PROG;
`endif
            end
            LOCKOUT: begin
                if (tc_c) begin
                    st_nxt    = ENTRY;
                    fails_nxt = 2'd0;
                end
            end
`ifdef COMBO_LOCK_PROGRAM_EN
            PROG: begin
                if (long_c) begin
                    st_nxt = ENTRY;
                end else if (short_c) begin
                    buf_nxt = put_digit(entry_buf, idx, enc);
                    if (idx == LAST_IDX) begin
                        code_nxt = buf_nxt;
                        st_nxt   = ENTRY;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
`endif
            default: st_nxt = ENTRY;
        endcase

        // Every arrival in a digit-collecting state starts from an empty buffer.
        if ((st_nxt != st) && ((st_nxt == ENTRY) || (st_nxt == PROG))) begin
            buf_nxt = '0;
            idx_nxt = 2'd0;
        end

        dv_nxt = 4'd0;
        ds_nxt = 3'd0;
        case (st_nxt)
            ENTRY:   begin dv_nxt = enc;                ds_nxt = {1'b0, idx_nxt}; end
            FAIL:    begin dv_nxt = {2'b00, fails_nxt}; ds_nxt = SEL_FAIL;        end
            OPEN:    begin dv_nxt = 4'd0;               ds_nxt = SEL_OPEN;        end
            LOCKOUT: begin dv_nxt = 4'd0;               ds_nxt = SEL_LOCK;        end
            PROG:    begin dv_nxt = enc;                ds_nxt = SEL_PROG;        end
            default: begin dv_nxt = 4'd0;               ds_nxt = 3'd0;            end
        endcase
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st             <= ENTRY;
            idx            <= 2'd0;
            entry_buf      <= '0;
            fail_cnt       <= 2'd0;
            display_value  <= 4'd0;
            display_select <= 3'd0;
            unlocked       <= 1'b0;
            lockout        <= 1'b0;
        end else begin
            st             <= st_nxt;
            idx            <= idx_nxt;
            entry_buf      <= buf_nxt;
            fail_cnt       <= fails_nxt;
            display_value  <= dv_nxt;
            display_select <= ds_nxt;
            unlocked       <= (st_nxt == OPEN);
            lockout        <= (st_nxt == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
`timescale 1ns/1ps
// tb_combo_lock_ctrl: scoreboard bench for combo_lock_ctrl. A driver steps a
// queue/string based reference model at each falling edge and queues the
// expected registered outputs; a monitor pops and compares after each rising edge.
module tb_combo_lock_ctrl;

    localparam int HOLD = 4;
    localparam int UNL  = 8;
    localparam int LCK  = 6;
    localparam int NMAX = 3;
`ifdef COMBO_LOCK_PROGRAM_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] enc = 4'd0;
    logic [2:0] pb_press_type = 3'd0;
    logic [3:0] display_value;
    logic [2:0] display_select;
    logic       unlocked;
    logic       lockout;
    logic [1:0] fail_cnt;

    always #5 clk = ~clk;

    combo_lock_ctrl #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAILS      (3),
        .HOLD_CYCLES    (HOLD),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enc            (enc),
        .pb_press_type  (pb_press_type),
        .display_value  (display_value),
        .display_select (display_select),
        .unlocked       (unlocked),
        .lockout        (lockout),
        .fail_cnt       (fail_cnt)
    );

    typedef struct {
        logic [3:0] dv;
        logic [2:0] ds;
        logic       un;
        logic       lo;
        logic [1:0] fc;
        bit         chk_ds;
        bit         chk_dv;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Reference model: mode name, digits typed so far, secret, failures, time in mode.
    string mode;
    int    entered[$];
    int    newcode[$];
    int    secret[4];
    int    fails;
    int    age;

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        mode = "entry";
        entered.delete();
        newcode.delete();
        secret = '{1, 2, 3, 4};
        fails = 0;
        age = 0;
    endfunction

    function automatic bit code_matches();
        if (entered.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (entered[i] != secret[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(input int e, input int p);
        string nxt;
        bit sp, lp;
        sp = (p == 1);
        lp = (p == 2);
        nxt = mode;
        if (mode == "entry") begin
            if (sp) begin
                entered.push_back(e);
                if (entered.size() == 4) nxt = "check";
            end else if (lp) begin
                entered.delete();
            end
        end else if (mode == "check") begin
            if (code_matches()) begin
                nxt = "open";
                fails = 0;
            end else begin
                if (fails < NMAX) fails++;
                nxt = (fails == NMAX) ? "lockout" : "fail";
            end
        end else if (mode == "fail") begin
            if (age == HOLD - 1) nxt = "entry";
        end else if (mode == "open") begin
            if (sp || age == UNL - 1) nxt = "entry";
            else if (lp && PROG_EN) nxt = "prog";
        end else if (mode == "lockout") begin
            if (age == LCK - 1) begin
                nxt = "entry";
                fails = 0;
            end
        end else if (mode == "prog") begin
            if (lp) nxt = "entry";
            else if (sp) begin
                newcode.push_back(e);
                if (newcode.size() == 4) begin
                    for (int i = 0; i < 4; i++) secret[i] = newcode[i];
                    nxt = "entry";
                end
            end
        end
        age = (nxt == mode) ? age + 1 : 0;
        if (nxt != mode && (nxt == "entry" || nxt == "prog")) begin
            entered.delete();
            newcode.delete();
        end
        mode = nxt;
    endfunction

    task automatic step_now(input int e, input int p);
        exp_t x;
        enc = 4'(e);
        pb_press_type = 3'(p);
        model_step(e, p);
        x.fc = 2'(fails);
        x.un = (mode == "open");
        x.lo = (mode == "lockout");
        x.dv = 4'd0;
        x.ds = 3'd0;
        x.chk_ds = 1'b1;
        x.chk_dv = 1'b1;
        if (mode == "entry") begin
            x.dv = 4'(e);
            x.ds = 3'(entered.size());
        end else if (mode == "fail") begin
            x.dv = 4'(fails);
            x.ds = 3'd5;
        end else if (mode == "open") begin
            x.ds = 3'd4;
        end else if (mode == "lockout") begin
            x.ds = 3'd6;
            x.chk_dv = 1'b0;
        end else if (mode == "prog") begin
            x.dv = 4'(e);
            x.ds = 3'd7;
        end else begin
            x.chk_ds = 1'b0;
            x.chk_dv = 1'b0;
        end
        sb.push_back(x);
    endtask

    task automatic step(input int e, input int p);
        @(negedge clk);
        step_now(e, p);
    endtask

    task automatic idle(input int n);
        repeat (n) step(int'($urandom_range(0, 15)), 0);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        step(a, 1);
        step(b, 1);
        step(c, 1);
        step(d, 1);
        idle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_display_value"}, int'(display_value), 0);
        cmp({tag, "_display_select"}, int'(display_select), 0);
        cmp({tag, "_unlocked"}, int'(unlocked), 0);
        cmp({tag, "_lockout"}, int'(lockout), 0);
        cmp({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        enc = 4'd0;
        pb_press_type = 3'd0;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        x = '{dv: 4'd0, ds: 3'd0, un: 1'b0, lo: 1'b0, fc: 2'd0, chk_ds: 1'b1, chk_dv: 1'b1};
        sb.push_back(x);
        @(negedge clk);
        rstn = 1'b1;
        step_now(0, 0);
    endtask

    // Monitor: one expected entry per rising edge while the driver is active.
    always begin
        exp_t x;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            cmp("unlocked", int'(unlocked), int'(x.un));
            cmp("lockout", int'(lockout), int'(x.lo));
            cmp("fail_cnt", int'(fail_cnt), int'(x.fc));
            if (x.chk_ds) cmp("display_select", int'(display_select), int'(x.ds));
            if (x.chk_dv) cmp("display_value", int'(display_value), int'(x.dv));
        end
    end

    initial begin
        int r, e, p, k;
        model_reset();
        #12 check_reset_outputs("power_on_reset");
        @(negedge clk);
        rstn = 1'b1;
        step_now(0, 0);

        // Correct code opens for the full unlock time, then relocks.
        enter(1, 2, 3, 4);
        idle(12);

        // One wrong code, then the right one clears the failure count.
        enter(1, 2, 3, 5);
        idle(6);
        enter(1, 2, 3, 4);
        idle(12);

        // Three wrong codes reach lockout; presses during lockout do nothing.
        enter(1, 2, 3, 5);
        idle(6);
        enter(9, 9, 9, 9);
        idle(6);
        enter(0, 0, 0, 0);
        step(1, 1);
        step(2, 2);
        step(3, 1);
        idle(6);

        // Partial entry abandoned by a long press, then a full correct entry.
        step(1, 1);
        step(2, 1);
        step(7, 2);
        enter(1, 2, 3, 4);
        idle(12);

        // Short press landing on the timeout cycle relocks exactly once.
        enter(1, 2, 3, 4);
        k = 0;
        while (k < 40 && !(mode == "open" && age == UNL - 1)) begin
            idle(1);
            k++;
        end
        checks++;
        if (!(mode == "open" && age == UNL - 1)) begin
            errors++;
            $display("FAIL timeout_align @cycle %0d: got waited %0d expected open at last cycle", cyc, k);
        end
        step(5, 1);
        idle(4);

        // Reset in the middle of an entry (two digits in).
        step(1, 1);
        step(2, 1);
        do_reset();
        enter(1, 2, 3, 4);
        idle(10);

        // Long press while open: programs a new code, or is ignored.
        enter(1, 2, 3, 4);
        step(0, 2);
`ifdef COMBO_LOCK_PROGRAM_EN
        enter(9, 8, 7, 6);
        idle(2);
        enter(1, 2, 3, 4);
        idle(6);
        enter(9, 8, 7, 6);
        idle(10);
`else
        idle(10);
`endif

        // Randomised traffic biased toward the correct digits.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15)      p = 1;
            else if (r < 20) p = 2;
            else if (r < 24) p = int'($urandom_range(3, 7));
            else             p = 0;
            if ((mode == "entry") && (entered.size() < 4) && ($urandom_range(0, 99) < 70))
                e = secret[entered.size()];
            else
                e = int'($urandom_range(0, 15));
            step(e, p);
        end

        @(negedge clk);
        pb_press_type = 3'd0;
        @(posedge clk);
        #3;
        cmp("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
